// File: rtl/fetch_unit.sv
// Instruction fetch: PC/IR registers with a FETCH/HOLD/HALT sequencer and next-PC select.
// One cycle from PC load to IRvalid; PC and IR hold until advance in HOLD, freeze in HALT.
module fetch_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PCinit,
  input  logic [31:0] IDataIn,
  output logic [31:0] IAddr,
  input  logic        advance,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] RegData,
  output logic [31:0] IR,
  output logic        IRvalid,
  output logic [31:0] PC4,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

  state_t      state, state_nxt;
  logic        boot;
  logic [31:0] pc_q;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] br_off;

  // boot selects PCinit until the first edge after reset, so PC follows PCinit
  // while reset is held without needing a non-constant reset value.
  assign pc      = boot ? PCinit : pc_q;
  assign IAddr   = pc;
  assign PC4     = pc + 32'd4;
  assign br_off  = {{14{IR[15]}}, IR[15:0], 2'b00};
  assign IRvalid = (state != FETCH);
  assign halted  = (state == HALT);

  always_comb begin
    next_pc = PC4;
    case (PCSrc)
      2'b00:   next_pc = PC4;
      2'b01:   next_pc = PC4 + br_off;
      2'b10:   next_pc = RegData & 32'hFFFF_FFFC;
      default: next_pc = {PC4[31:28], IR[25:0], 2'b00};
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = (IDataIn[31:26] == 6'h3F) ? HALT : HOLD;
      HOLD:    if (advance) state_nxt = FETCH;
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      boot <= 1'b1;
      pc_q <= 32'h0;
      IR   <= 32'h0;
    end else begin
      boot <= 1'b0;
      pc_q <= pc;
      if (state == FETCH) begin
        IR <= IDataIn;
      end
      if (state == HOLD && advance) begin
        pc_q <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed boot/branch/jr/halt/reset scenarios plus randomized runs against a model.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic [31:0] PCinit;
  logic [31:0] IDataIn;
  logic [31:0] IAddr;
  logic        advance;
  logic [1:0]  PCSrc;
  logic [31:0] RegData;
  logic [31:0] IR;
  logic        IRvalid;
  logic [31:0] PC4;
  logic        halted;

  int checks;
  int errors;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .PCinit(PCinit), .IDataIn(IDataIn), .IAddr(IAddr),
    .advance(advance), .PCSrc(PCSrc), .RegData(RegData), .IR(IR),
    .IRvalid(IRvalid), .PC4(PC4), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Pulses reset between edges; the next rising edge is the first capture edge.
  task automatic do_reset(input logic [31:0] init);
    RST = 1'b1;
    PCinit = init;
    advance = 1'b0;
    #2;
    RST = 1'b0;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
                                             input logic [1:0] src, input logic [31:0] rd);
    int off;
    off = int'($signed(ir[15:0]));
    case (src)
      2'd0:    return pc + 32'd4;
      2'd1:    return pc + 32'd4 + 32'(off * 4);
      2'd2:    return (rd >> 2) << 2;
      default: return ((pc + 32'd4) & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
    endcase
  endfunction

  task automatic test_reset();
    RST = 1'b1; PCinit = 32'h40; IDataIn = 32'h0; advance = 1'b0; PCSrc = 2'd0; RegData = 32'h0;
    #1;
    checks++; if (IAddr !== 32'h40) begin errors++; $display("FAIL rst_iaddr got %h want %h", IAddr, 32'h40); end
    checks++; if (PC4 !== 32'h44) begin errors++; $display("FAIL rst_pc4 got %h want %h", PC4, 32'h44); end
    checks++; if (IR !== 32'h0) begin errors++; $display("FAIL rst_ir got %h want 0", IR); end
    checks++; if (IRvalid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rst_flags got v=%b h=%b want 0 0", IRvalid, halted); end
    PCinit = 32'h80;
    #1;
    checks++; if (IAddr !== 32'h80) begin errors++; $display("FAIL rst_track got %h want %h", IAddr, 32'h80); end
    step();
    checks++; if (IRvalid !== 1'b0 || IAddr !== 32'h80) begin errors++; $display("FAIL rst_held got v=%b pc=%h want 0 80", IRvalid, IAddr); end
  endtask

  task automatic test_boot_jump();
    IDataIn = 32'hE000_0040;
    do_reset(32'h0);
    checks++; if (IRvalid !== 1'b0 || IAddr !== 32'h0) begin errors++; $display("FAIL boot_pre got v=%b pc=%h want 0 0", IRvalid, IAddr); end
    step();
    checks++; if (IR !== 32'hE000_0040 || IRvalid !== 1'b1) begin errors++; $display("FAIL boot_ir got %h v=%b want e0000040 1", IR, IRvalid); end
    IDataIn = 32'h1234_5678;
    step();
    checks++; if (IR !== 32'hE000_0040) begin errors++; $display("FAIL ir_stable got %h want e0000040", IR); end
    advance = 1'b1; PCSrc = 2'd3;
    step();
    checks++; if (IAddr !== 32'h100 || IRvalid !== 1'b0) begin errors++; $display("FAIL boot_jump got %h v=%b want 00000100 0", IAddr, IRvalid); end
  endtask

  task automatic test_sequential();
    IDataIn = 32'h0; advance = 1'b1; PCSrc = 2'd0;
    step();
    checks++; if (IAddr !== 32'h100 || IRvalid !== 1'b1) begin errors++; $display("FAIL seq_capture_ignore got %h v=%b want 100 1", IAddr, IRvalid); end
    step();
    checks++; if (IAddr !== 32'h104 || IRvalid !== 1'b0) begin errors++; $display("FAIL seq_104 got %h v=%b want 104 0", IAddr, IRvalid); end
    step();
    checks++; if (IAddr !== 32'h104 || IRvalid !== 1'b1) begin errors++; $display("FAIL seq_fetch_ignore got %h v=%b want 104 1", IAddr, IRvalid); end
    step();
    checks++; if (IAddr !== 32'h108 || PC4 !== 32'h10C || IRvalid !== 1'b0) begin errors++; $display("FAIL seq_108 got %h %h v=%b want 108 10c 0", IAddr, PC4, IRvalid); end
    advance = 1'b0;
    step();
    checks++; if (IRvalid !== 1'b1 || IAddr !== 32'h108) begin errors++; $display("FAIL seq_valid got v=%b pc=%h want 1 108", IRvalid, IAddr); end
    step();
    checks++; if (IRvalid !== 1'b1) begin errors++; $display("FAIL seq_one_cycle got v=%b want 1", IRvalid); end
  endtask

  task automatic test_branch_jr();
    logic [31:0] inits [4];
    logic [31:0] instr [4];
    logic [1:0]  srcs  [4];
    logic [31:0] rds   [4];
    logic [31:0] exps  [4];
    inits = '{32'h20, 32'h134, 32'h200, 32'h200};
    instr = '{32'hD068_0005, 32'hD0A9_FFFA, 32'h0, 32'h0};
    srcs  = '{2'd1, 2'd1, 2'd2, 2'd2};
    rds   = '{32'h0, 32'h0, 32'h120, 32'h123};
    exps  = '{32'h38, 32'h120, 32'h120, 32'h120};
    for (int i = 0; i < 4; i++) begin
      step();
      IDataIn = instr[i];
      do_reset(inits[i]);
      step();
      advance = 1'b1; PCSrc = srcs[i]; RegData = rds[i];
      step();
      advance = 1'b0;
      checks++; if (IAddr !== exps[i]) begin errors++; $display("FAIL br_jr[%0d] got %h want %h", i, IAddr, exps[i]); end
    end
  endtask

  task automatic test_halt();
    step();
    IDataIn = 32'hFC00_0000;
    do_reset(32'h300);
    step();
    checks++; if (halted !== 1'b1 || IRvalid !== 1'b1) begin errors++; $display("FAIL halt_enter got h=%b v=%b want 1 1", halted, IRvalid); end
    for (int i = 0; i < 10; i++) begin
      advance = 1'b1; PCSrc = 2'($urandom_range(0, 3)); IDataIn = $urandom; RegData = $urandom;
      step();
      checks++; if (IAddr !== 32'h300 || IR !== 32'hFC00_0000 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_frozen[%0d] got pc=%h ir=%h h=%b want 300 fc000000 1", i, IAddr, IR, halted);
      end
    end
    advance = 1'b0;
    RST = 1'b1;
    #1;
    checks++; if (halted !== 1'b0 || IRvalid !== 1'b0) begin errors++; $display("FAIL halt_exit got h=%b v=%b want 0 0", halted, IRvalid); end
    RST = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    step();
    IDataIn = 32'h0;
    do_reset(32'h500);
    step();
    advance = 1'b1; PCSrc = 2'd0;
    step();
    advance = 1'b0;
    #3;
    RST = 1'b1; PCinit = 32'h40;
    #1;
    checks++; if (IAddr !== 32'h40 || IR !== 32'h0 || IRvalid !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL mid_fetch_rst got pc=%h ir=%h v=%b h=%b want 40 0 0 0", IAddr, IR, IRvalid, halted);
    end
    #1;
    RST = 1'b0;
    IDataIn = 32'h0000_ABCD;
    step();
    checks++; if (IR !== 32'h0000_ABCD || IAddr !== 32'h40) begin errors++; $display("FAIL post_rst_fetch got ir=%h pc=%h want 0000abcd 40", IR, IAddr); end
  endtask

  task automatic test_random(input logic [31:0] init, input int cycles);
    logic [31:0] m_pc, m_ir, din, rd;
    logic        m_valid, adv;
    logic [1:0]  src;
    step();
    do_reset(init);
    m_pc = init; m_ir = 32'h0; m_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      adv = 1'($urandom_range(0, 1));
      src = 2'($urandom_range(0, 3));
      rd  = $urandom;
      din = $urandom;
      if (din[31:26] == 6'h3F) din[26] = 1'b0;
      advance = adv; PCSrc = src; RegData = rd; IDataIn = din;
      if (!m_valid) begin
        m_ir = din;
        m_valid = 1'b1;
      end else if (adv) begin
        m_pc = model_next(m_pc, m_ir, src, rd);
        m_valid = 1'b0;
      end
      step();
      checks++; if (IAddr !== m_pc || PC4 !== m_pc + 32'd4 || IR !== m_ir || IRvalid !== m_valid || halted !== 1'b0) begin
        errors++;
        $display("FAIL rand[%0d] got pc=%h pc4=%h ir=%h v=%b h=%b want %h %h %h %b 0",
                 i, IAddr, PC4, IR, IRvalid, halted, m_pc, m_pc + 32'd4, m_ir, m_valid);
      end
    end
    advance = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_boot_jump();
    test_sequential();
    test_branch_jr();
    test_halt();
    test_reset_mid_fetch();
    test_random($urandom & 32'hFFFF_FFFC, 300);
    test_random(32'hFFFF_FFF0, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-high.
REQ-002 The ports SHALL be exactly these:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- PCinit  in  32  boot address.
- IDataIn  in  32  instruction word returned by the instruction memory for IAddr.
- IAddr  out  32  fetch address driven to the instruction memory; always equals PC.
- advance  in  1  the control unit has retired the current instruction; load next PC.
- PCSrc  in  2  next-PC select: 00 PC+4, 01 branch, 10 register (jr), 11 jump.
- RegData  in  32  rs register value used as the jr target.
- IR  out  32  latched instruction.
- IRvalid  out  1  IR holds the instruction at PC.
- PC4  out  32  PC+4, used as the jal link value.
- halted  out  1  a halt instruction has been fetched.

Function
REQ-003 The block SHALL hold a 32-bit PC register, a 32-bit IR register, and a three-state FSM: FETCH, HOLD, HALT.
REQ-004 IAddr SHALL be combinationally equal to PC, and PC4 SHALL equal PC+4 modulo 2^32.
REQ-005 In FETCH, the block SHALL give the memory one full cycle to settle, then on the next rising edge latch IDataIn into IR.
- If IDataIn[31:26] is 111111, the FSM SHALL go to HALT.
- Otherwise the FSM SHALL go to HOLD.
REQ-006 IRvalid SHALL be 1 in HOLD and HALT and 0 in FETCH, so fetch latency is 1 cycle from PC load to IRvalid=1.
REQ-007 In FETCH, advance SHALL be ignored.
REQ-008 In HOLD with advance=1, on the edge the block SHALL load PC with the next-PC value and go to FETCH (IRvalid=0 the following cycle); with advance=0 it SHALL hold PC and IR.
REQ-009 The next-PC value SHALL be computed from the current IR as follows:
- 00: PC+4.
- 01: PC+4 + (sign-extended IR[15:0] << 2).
- 10: {RegData[31:2], 2'b00}, so the low two bits are always cleared.
- 11: {PC4[31:28], IR[25:0], 2'b00}.
REQ-010 All next-PC arithmetic SHALL be 32-bit and wrap modulo 2^32 with no overflow flag.
REQ-011 In HALT, halted SHALL be 1, and PC and IR SHALL be frozen.
- advance and PCSrc SHALL be ignored.
- Only RST exits HALT.
REQ-012 Changes on IDataIn outside the FETCH capture edge SHALL NOT affect IR.
REQ-013 If advance=1 arrives in the same cycle the FSM enters HOLD (the capture edge), it SHALL NOT take effect until the next edge.

Reset
REQ-014 While RST=1 the block SHALL force the following, independent of CLK:
- PC = PCinit (PC tracks PCinit while RST is held).
- IR = 32'h0, IRvalid = 0, halted = 0.
- FSM = FETCH.
REQ-015 The first rising edge after RST falls SHALL capture memory[PCinit] into IR.
REQ-016 RST asserted in any state, including mid-FETCH or in HALT, SHALL abandon the in-flight instruction immediately and apply REQ-014.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Boot jump: PCinit=0, IDataIn=32'hE0000040 at 0; release RST; after 1 edge, IR=E0000040 and IRvalid=1; advance with PCSrc=11 -> PC=IAddr=32'h00000100.
- Sequential: PC=0x104, advance with PCSrc=00 -> PC=0x108 and PC4=0x10C; IRvalid is 0 for exactly one cycle.
- Branches: PC=0x20 with IR=32'hD0680005, PCSrc=01 -> PC=0x38; PC=0x134 with IR=32'hD0A9FFFA, PCSrc=01 -> PC=0x120.
- jr alignment: PCSrc=10 with RegData=0x120 -> PC=0x120; with RegData=0x123 -> PC=0x120.
- Halt: fetch 32'hFC000000 -> halted=1 and IRvalid=1; 10 cycles of advance=1 with any PCSrc leave PC and IR unchanged.
- Reset mid-FETCH: pulse RST between edges with PCinit=0x40 -> PC=0x40, IR=0, IRvalid=0 and halted=0 immediately, with no clock edge required.
